id_ex_ctrl_stage: RTL and testbench

//  ID/EX pipeline stage for the control path. Registers control-unit outputs and ID operand

---
 rtl/id_ex_ctrl_stage_if.sv | 62 ++++++
 rtl/id_ex_ctrl_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_ctrl_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/id_ex_ctrl_stage_if.sv
// ID/EX control-path bundle: ID-side control/operand fields in, EX-side registered fields,
// hazard/squash strobes and event counters out.
interface id_ex_ctrl_stage_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 16
);
  logic               id_valid;
  logic               id_wen;
  logic               id_alusrc;
  logic               id_regdst;
  logic               id_branch;
  logic               id_memwrite;
  logic               id_memread;
  logic               id_memtoreg;
  logic               id_jr;
  logic               id_jump;
  logic               id_jal;
  logic [ALUOP_W-1:0] id_aluop;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               id_uses_rt;
  logic               ex_br_taken;

  logic               ex_valid;
  logic               ex_wen;
  logic               ex_alusrc;
  logic               ex_regdst;
  logic               ex_branch;
  logic               ex_memwrite;
  logic               ex_memread;
  logic               ex_memtoreg;
  logic               ex_jr;
  logic               ex_jump;
  logic               ex_jal;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [REG_AW-1:0]  ex_rt;
  logic [REG_AW-1:0]  ex_rd;
  logic               stall_o;
  logic               flush_ifid_o;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output id_valid, id_wen, id_alusrc, id_regdst, id_branch, id_memwrite, id_memread,
           id_memtoreg, id_jr, id_jump, id_jal, id_aluop, id_rs, id_rt, id_rd, id_uses_rt,
           ex_br_taken,
    input  ex_valid, ex_wen, ex_alusrc, ex_regdst, ex_branch, ex_memwrite, ex_memread,
           ex_memtoreg, ex_jr, ex_jump, ex_jal, ex_aluop, ex_rt, ex_rd, stall_o, flush_ifid_o,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_wen, id_alusrc, id_regdst, id_branch, id_memwrite, id_memread,
           id_memtoreg, id_jr, id_jump, id_jal, id_aluop, id_rs, id_rt, id_rd, id_uses_rt,
           ex_br_taken,
    output ex_valid, ex_wen, ex_alusrc, ex_regdst, ex_branch, ex_memwrite, ex_memread,
           ex_memtoreg, ex_jr, ex_jump, ex_jal, ex_aluop, ex_rt, ex_rd, stall_o, flush_ifid_o,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control-path pipeline register with load-use stall, branch/jump squash and
// saturating stall/flush event counters.
module id_ex_ctrl_stage #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_ctrl_stage_if.slave bus
);

  typedef struct packed {
    logic               wen;
    logic               alusrc;
    logic               regdst;
    logic               branch;
    logic               memwrite;
    logic               memread;
    logic               memtoreg;
    logic               jr;
    logic               jump;
    logic               jal;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
  } ex_fields_t;

  logic             ex_valid_q,  ex_valid_d;
  ex_fields_t       ex_q,        ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  ex_fields_t id_fields;
  logic       hazard;
  logic       id_jump_any;
  logic       stall;
  logic       flush_ifid;

  always_comb begin
    id_fields.wen      = bus.id_wen;
    id_fields.alusrc   = bus.id_alusrc;
    id_fields.regdst   = bus.id_regdst;
    id_fields.branch   = bus.id_branch;
    id_fields.memwrite = bus.id_memwrite;
    id_fields.memread  = bus.id_memread;
    id_fields.memtoreg = bus.id_memtoreg;
    id_fields.jr       = bus.id_jr;
    id_fields.jump     = bus.id_jump;
    id_fields.jal      = bus.id_jal;
    id_fields.aluop    = bus.id_aluop;
    id_fields.rt       = bus.id_rt;
    id_fields.rd       = bus.id_rd;
  end

  // id_valid gates every term so garbage on an empty ID slot cannot stall or squash
  assign hazard = ex_valid_q & ex_q.memread & bus.id_valid & (ex_q.rt != '0) &
                  ((ex_q.rt == bus.id_rs) | (bus.id_uses_rt & (ex_q.rt == bus.id_rt)));

  assign id_jump_any = bus.id_valid & (bus.id_jump | bus.id_jal);

  always_comb begin
    ex_valid_d = 1'b0;
    ex_d       = '0;
    stall      = 1'b0;
    flush_ifid = 1'b0;
    if (bus.ex_br_taken) begin
      // ID holds a wrong-path instruction; dropping it outranks any stall it would cause
      flush_ifid = 1'b1;
    end else if (hazard) begin
      stall = 1'b1;
    end else begin
      ex_valid_d = bus.id_valid;
      if (bus.id_valid) begin
        ex_d = id_fields;
      end
      if (id_jump_any) begin
        flush_ifid = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_ifid && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_wen       = ex_q.wen;
  assign bus.ex_alusrc    = ex_q.alusrc;
  assign bus.ex_regdst    = ex_q.regdst;
  assign bus.ex_branch    = ex_q.branch;
  assign bus.ex_memwrite  = ex_q.memwrite;
  assign bus.ex_memread   = ex_q.memread;
  assign bus.ex_memtoreg  = ex_q.memtoreg;
  assign bus.ex_jr        = ex_q.jr;
  assign bus.ex_jump      = ex_q.jump;
  assign bus.ex_jal       = ex_q.jal;
  assign bus.ex_aluop     = ex_q.aluop;
  assign bus.ex_rt        = ex_q.rt;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.stall_o      = stall;
  assign bus.flush_ifid_o = flush_ifid;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them.
module tb_id_ex_ctrl_stage;

  localparam int unsigned CW = 4;

  // control vector order: wen alusrc regdst branch memwrite memread memtoreg jr jump jal
  localparam logic [9:0] C_NONE = 10'b0000000000;
  localparam logic [9:0] C_LW   = 10'b1100011000;
  localparam logic [9:0] C_SW   = 10'b0100100000;
  localparam logic [9:0] C_ADD  = 10'b1010000000;
  localparam logic [9:0] C_ADDI = 10'b1100000000;
  localparam logic [9:0] C_J    = 10'b0000000010;
  localparam logic [9:0] C_ALL  = 10'b1111111111;

  logic clk;
  logic rst_n;

  id_ex_ctrl_stage_if #(.REG_AW(5), .ALUOP_W(3), .CNT_W(CW)) bus ();

  id_ex_ctrl_stage #(.REG_AW(5), .ALUOP_W(3), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic        st;
    logic        fl;
    logic        ev;
    logic [9:0]  ec;
    logic [12:0] ef;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input string tag, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s [%s]: got %0h, expected %0h", name, tag, act, req);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall_o",      e.tag, 32'(bus.stall_o),      32'(e.st));
      chk("flush_ifid_o", e.tag, 32'(bus.flush_ifid_o), 32'(e.fl));
      chk("ex_valid",     e.tag, 32'(bus.ex_valid),     32'(e.ev));
      chk("ex_ctrl",      e.tag,
          32'({bus.ex_wen, bus.ex_alusrc, bus.ex_regdst, bus.ex_branch, bus.ex_memwrite,
               bus.ex_memread, bus.ex_memtoreg, bus.ex_jr, bus.ex_jump, bus.ex_jal}),
          32'(e.ec));
      chk("ex_alu_rt_rd", e.tag, 32'({bus.ex_aluop, bus.ex_rt, bus.ex_rd}), 32'(e.ef));
      chk("stall_cnt",    e.tag, 32'(bus.stall_cnt),    32'(e.sc));
      chk("flush_cnt",    e.tag, 32'(bus.flush_cnt),    32'(e.fc));
    end
  end

  // one cycle: drive ID/branch inputs just after the edge, expect the EX state left by the
  // previous edge plus the strobes those inputs produce
  task automatic cyc(input string tag, input logic rstn_v,
                     input logic v, input logic [9:0] c, input logic [2:0] alu,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic ur, input logic br,
                     input logic est, input logic efl, input logic eev, input logic [9:0] eec,
                     input logic [2:0] ealu, input logic [4:0] ert, input logic [4:0] erd,
                     input logic [3:0] esc, input logic [3:0] efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rstn_v;
    bus.id_valid = v;
    {bus.id_wen, bus.id_alusrc, bus.id_regdst, bus.id_branch, bus.id_memwrite,
     bus.id_memread, bus.id_memtoreg, bus.id_jr, bus.id_jump, bus.id_jal} = c;
    bus.id_aluop = alu;
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_rd = rd;
    bus.id_uses_rt = ur;
    bus.ex_br_taken = br;
    e.tag = tag;
    e.st = est;
    e.fl = efl;
    e.ev = eev;
    e.ec = eec;
    e.ef = {ealu, ert, erd};
    e.sc = esc;
    e.fc = efc;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sc;
    rst_n = 1'b0;
    bus.id_valid = 1'b0;
    {bus.id_wen, bus.id_alusrc, bus.id_regdst, bus.id_branch, bus.id_memwrite,
     bus.id_memread, bus.id_memtoreg, bus.id_jr, bus.id_jump, bus.id_jal} = C_NONE;
    bus.id_aluop = '0;
    bus.id_rs = '0;
    bus.id_rt = '0;
    bus.id_rd = '0;
    bus.id_uses_rt = 1'b0;
    bus.ex_br_taken = 1'b0;
    repeat (2) @(posedge clk);

    //  tag          rst v  ctrl    alu     rs rt rd ur br | st fl ev ectrl   ealu   ert erd sc fc
    cyc("reset",     1, 0, C_NONE, 3'd0,   0, 0, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0,  0, 0);
    // load-use: LW rt=5 then ADD rs=5
    cyc("t2_lw",     1, 1, C_LW,   3'b010, 1, 5, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0,  0, 0);
    cyc("t2_stall",  1, 1, C_ADD,  3'b100, 5, 6, 7, 1, 0,  1, 0, 1, C_LW,   3'b010,5, 0,  0, 0);
    cyc("t2_bubble", 1, 1, C_ADD,  3'b100, 5, 6, 7, 1, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0,  1, 0);
    cyc("t2_add_ex", 1, 1, C_SW,   3'b010, 3, 4, 0, 1, 0,  0, 0, 1, C_ADD,  3'b100,6, 7,  1, 0);
    // async reset with SW (memwrite) in EX and a nonzero stall count
    cyc("t1_rst",    0, 0, C_NONE, 3'd0,   0, 0, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0,  0, 0);
    cyc("t1_post",   1, 0, C_NONE, 3'd0,   0, 0, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0,  0, 0);
    // no hazard on rt=0, nor when ID does not read rt
    cyc("t3_lw0",    1, 1, C_LW,   3'b010, 1, 0, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0,  0, 0);
    cyc("t3_r0",     1, 1, C_ADD,  3'b100, 0, 0, 8, 1, 0,  0, 0, 1, C_LW,   3'b010,0, 0,  0, 0);
    cyc("t3_lw5",    1, 1, C_LW,   3'b010, 2, 5, 0, 0, 0,  0, 0, 1, C_ADD,  3'b100,0, 8,  0, 0);
    cyc("t3_addi",   1, 1, C_ADDI, 3'b010, 9, 5, 0, 0, 0,  0, 0, 1, C_LW,   3'b010,5, 0,  0, 0);
    // branch taken in the same cycle as a hazard
    cyc("t4_lw",     1, 1, C_LW,   3'b010, 1, 5, 0, 0, 0,  0, 0, 1, C_ADDI, 3'b010,5, 0,  0, 0);
    cyc("t4_br",     1, 1, C_ADD,  3'b100, 5, 6, 7, 1, 1,  0, 1, 1, C_LW,   3'b010,5, 0,  0, 0);
    // jump: delay-slot squash, then an invalid (garbage) ID slot
    cyc("t5_j",      1, 1, C_J,    3'd0,   0, 0, 0, 0, 0,  0, 1, 0, C_NONE, 3'd0,  0, 0,  0, 1);
    cyc("t5_sq",     1, 0, C_ALL,  3'b111, 31,31,31,1, 0,  0, 0, 1, C_J,    3'd0,  0, 0,  0, 2);
    cyc("t5_idle",   1, 0, C_NONE, 3'd0,   0, 0, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0,  0, 2);
    // invalid ID that would otherwise match a load in EX
    cyc("inv_lw",    1, 1, C_LW,   3'b010, 1, 5, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0,  0, 2);
    cyc("inv_hz",    1, 0, C_ALL,  3'b111, 5, 5, 5, 1, 0,  0, 0, 1, C_LW,   3'b010,5, 0,  0, 2);

    // stall counter saturation: 2^4+3 stalls
    for (int i = 0; i < 19; i++) begin
      sc = (i > 15) ? 4'd15 : 4'(i);
      cyc("t6_lw",   1, 1, C_LW,   3'b010, 1, 5, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0, sc, 2);
      cyc("t6_stall",1, 1, C_ADD,  3'b100, 5, 6, 7, 1, 0,  1, 0, 1, C_LW,   3'b010,5, 0, sc, 2);
    end
    cyc("t6_sat",    1, 0, C_NONE, 3'd0,   0, 0, 0, 0, 0,  0, 0, 0, C_NONE, 3'd0,  0, 0, 15, 2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
